layer_sequencer: RTL

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

---
 rtl/nnfc_pkg.sv | 24 ++
 rtl/layer_sequencer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/nnfc_pkg.sv
// Shared definitions for the layer sequencer: default geometry and FSM state encoding.
package nnfc_pkg;

    localparam int unsigned NUM_MACS_DEF   = 4;
    localparam int unsigned ADDR_WIDTH_DEF = 10;
    localparam int unsigned TILE_WIDTH_DEF = 8;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_FETCH   = 3'd2;
    localparam logic [2:0] ST_COMPUTE = 3'd3;
    localparam logic [2:0] ST_NEXT    = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    typedef enum logic [2:0] {
        StIdle    = ST_IDLE,
        StLoad    = ST_LOAD,
        StFetch   = ST_FETCH,
        StCompute = ST_COMPUTE,
        StNext    = ST_NEXT,
        StDone    = ST_DONE
    } seq_state_e;

endpackage

// File: rtl/layer_sequencer.sv
// Walks a layer tile by tile: reset/configure the fetch arbiter, wait for fetch,
// kick all MAC lanes, collect their completions, then step the base address.
module layer_sequencer
    import nnfc_pkg::*;
#(
    parameter int unsigned NUM_MACS   = NUM_MACS_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned TILE_WIDTH = TILE_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [ADDR_WIDTH-1:0] cfg_stride,
    input  logic [ADDR_WIDTH-1:0] cfg_start_offset,
    input  logic [TILE_WIDTH-1:0] cfg_num_tiles,
    output logic                  busy,
    output logic                  done,
    output logic [TILE_WIDTH-1:0] tile_idx,
    output logic                  arb_rst,
    output logic                  arb_en,
    output logic [ADDR_WIDTH-1:0] arb_base_addr,
    output logic [ADDR_WIDTH-1:0] arb_start_offset,
    output logic [ADDR_WIDTH-1:0] arb_stride,
    input  logic                  arb_all_done,
    output logic [NUM_MACS-1:0]   mac_start,
    input  logic [NUM_MACS-1:0]   mac_done
);

    function automatic logic [ADDR_WIDTH-1:0] step_base(input logic [ADDR_WIDTH-1:0] base,
                                                        input logic [ADDR_WIDTH-1:0] stride);
        return base + stride * ADDR_WIDTH'(NUM_MACS);
    endfunction

    seq_state_e            r_state, w_state_d;
    logic [TILE_WIDTH-1:0] r_tile_idx, w_tile_idx_d;
    logic [TILE_WIDTH-1:0] r_num_tiles, w_num_tiles_d;
    logic [ADDR_WIDTH-1:0] r_base, w_base_d;
    logic [ADDR_WIDTH-1:0] r_offset, w_offset_d;
    logic [ADDR_WIDTH-1:0] r_stride, w_stride_d;
    logic [NUM_MACS-1:0]   r_mask, w_mask_d;
    logic [NUM_MACS-1:0]   w_mask_or;
    logic                  r_busy, w_busy_d;
    logic                  r_done, w_done_d;
    logic                  r_arb_rst, w_arb_rst_d;
    logic                  r_arb_en, w_arb_en_d;
    logic [NUM_MACS-1:0]   r_mac_start, w_mac_start_d;

    assign w_mask_or = r_mask | mac_done;

    always_comb begin
        w_state_d     = r_state;
        w_tile_idx_d  = r_tile_idx;
        w_num_tiles_d = r_num_tiles;
        w_base_d      = r_base;
        w_offset_d    = r_offset;
        w_stride_d    = r_stride;
        w_mask_d      = r_mask;

        case (r_state)
            StIdle: begin
                if (start) begin
                    w_base_d      = cfg_base_addr;
                    w_offset_d    = cfg_start_offset;
                    w_stride_d    = cfg_stride;
                    w_num_tiles_d = cfg_num_tiles;
                    w_tile_idx_d  = '0;
                    w_state_d     = (cfg_num_tiles == '0) ? StDone : StLoad;
                end
            end
            StLoad: w_state_d = StFetch;
            StFetch: begin
                if (arb_all_done) begin
                    w_mask_d  = '0;
                    w_state_d = StCompute;
                end
            end
            StCompute: begin
                w_mask_d = w_mask_or;
                if (&w_mask_or) begin
                    w_state_d = StNext;
                end
            end
            StNext: begin
                if (r_tile_idx == r_num_tiles - TILE_WIDTH'(1)) begin
                    w_state_d = StDone;
                end else begin
                    w_tile_idx_d = r_tile_idx + TILE_WIDTH'(1);
                    w_base_d     = step_base(r_base, r_stride);
                    w_state_d    = StLoad;
                end
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase

        // Outputs are decoded from the next state so the registered copy lines up with it.
        w_busy_d      = (w_state_d != StIdle);
        w_done_d      = (w_state_d == StDone);
        w_arb_rst_d   = (w_state_d == StLoad);
        w_arb_en_d    = (w_state_d == StFetch);
        w_mac_start_d = {NUM_MACS{(w_state_d == StCompute) && (r_state != StCompute)}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_tile_idx  <= '0;
            r_num_tiles <= '0;
            r_base      <= '0;
            r_offset    <= '0;
            r_stride    <= '0;
            r_mask      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            // Held high through reset so the arbiter is reset alongside us.
            r_arb_rst   <= 1'b1;
            r_arb_en    <= 1'b0;
            r_mac_start <= '0;
        end else begin
            r_state     <= w_state_d;
            r_tile_idx  <= w_tile_idx_d;
            r_num_tiles <= w_num_tiles_d;
            r_base      <= w_base_d;
            r_offset    <= w_offset_d;
            r_stride    <= w_stride_d;
            r_mask      <= w_mask_d;
            r_busy      <= w_busy_d;
            r_done      <= w_done_d;
            r_arb_rst   <= w_arb_rst_d;
            r_arb_en    <= w_arb_en_d;
            r_mac_start <= w_mac_start_d;
        end
    end

    assign busy             = r_busy;
    assign done             = r_done;
    assign tile_idx         = r_tile_idx;
    assign arb_rst          = r_arb_rst;
    assign arb_en           = r_arb_en;
    assign arb_base_addr    = r_base;
    assign arb_start_offset = r_offset;
    assign arb_stride       = r_stride;
    assign mac_start        = r_mac_start;

endmodule
